// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Each operation is granted in IDLE, evaluated in EXEC and held in RESP until it is consumed.
module alu_arbiter #(
  parameter int unsigned W  = 18,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0_valid,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic [1:0]    req0_sel,
  output logic          req0_ready,

  input  logic          req1_valid,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  input  logic [1:0]    req1_sel,
  output logic          req1_ready,

  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [1:0]    alu_sel,
  input  logic [W-1:0]  alu_c,
  input  logic          alu_z,

  output logic          rsp_valid,
  output logic [W-1:0]  rsp_c,
  output logic          rsp_z,
  output logic          rsp_id,
  input  logic          rsp_ready,

  output logic          busy,
  output logic [CW-1:0] op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic [W-1:0]   a_q, b_q;
  logic [1:0]     sel_q;
  logic           id_q;
  logic [W-1:0]   rsp_c_q;
  logic           rsp_z_q;
  logic [CW-1:0]  cnt_q;

  logic           gnt0, gnt1;
  logic           accept;
  logic           consume;

  // Grants are only offered from IDLE and never while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign consume    = (state_q == StResp) && rsp_ready;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          // Hand priority to the requester that was not just served.
          prio_d  = ~id_q;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      id_q    <= 1'b0;
      rsp_c_q <= '0;
      rsp_z_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (accept) begin
        a_q   <= gnt1 ? req1_a   : req0_a;
        b_q   <= gnt1 ? req1_b   : req0_b;
        sel_q <= gnt1 ? req1_sel : req0_sel;
        id_q  <= gnt1;
      end
      if (state_q == StExec) begin
        rsp_c_q <= alu_c;
        rsp_z_q <= alu_z;
      end
      if (consume && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;

  assign rsp_valid = (state_q == StResp);
  assign rsp_c     = rsp_c_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_id    = id_q;

  assign busy      = (state_q != StIdle);
  assign op_count  = cnt_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter W, default 18, is the operand and result width of the shared ALU.
REQ-002 Parameter CW, default 16, is the width of the completed-operation counter.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req0_valid, req1_valid  input  1 each  indicate that requester 0 or 1 presents an operation.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  W each  are the operands of each requester.
REQ-007 req0_sel, req1_sel  input  2 each  are the ALU operation selects of each requester.
REQ-008 req0_ready, req1_ready  output  1 each  are accept strobes; a transfer occurs when valid and ready are both high at a clock edge.
REQ-009 alu_a, alu_b  output  W each  drive the operand ports of the external ALU.
REQ-010 alu_sel  output  2  drives the operation select of the external ALU.
REQ-011 alu_c  input  W  and  alu_z  input  1  are the combinational ALU result and zero flag.
REQ-012 rsp_valid  output  1  indicates that a result is held.
REQ-013 rsp_c  output  W,  rsp_z  output  1,  rsp_id  output  1  carry the result, the zero flag and the owning requester.
REQ-014 rsp_ready  input  1  is the consumer accept; the response is consumed when rsp_valid and rsp_ready are both high at an edge.
REQ-015 busy  output  1  is high in every state except IDLE.
REQ-016 op_count  output  CW  counts consumed responses.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-018 In IDLE, with exactly one valid requester, that requester SHALL be granted: its ready is combinationally high, and all other readies are low.
REQ-019 In IDLE, with both requesters valid, the grant SHALL go to the requester indicated by the 1-bit priority pointer prio (0 selects req0).
REQ-020 On an accepting edge: a, b and sel SHALL be latched into internal registers, the winner id SHALL be latched, and the state SHALL become EXEC.
REQ-021 Outside IDLE, both readies SHALL be 0, and new requests SHALL wait; their inputs are ignored.
REQ-022 alu_a, alu_b and alu_sel SHALL always drive the latched operand registers, so the ALU inputs are stable from EXEC onward.
REQ-023 In EXEC, alu_c and alu_z SHALL be captured into rsp_c and rsp_z at the next edge, the state SHALL become RESP, and rsp_valid SHALL rise.
REQ-024 Latency SHALL be fixed: rsp_valid is high on the second edge after the accepting edge.
REQ-025 In RESP, rsp_c, rsp_z and rsp_id SHALL hold stable while rsp_ready is low (backpressure of unbounded length).
REQ-026 On a consuming edge, all of the following SHALL occur: the state returns to IDLE; rsp_valid falls; prio is set to the inverse of rsp_id; op_count increments.
REQ-027 A new accept SHALL NOT occur in the same cycle as consumption; the earliest next accept is the cycle after return to IDLE, giving a 3-cycle minimum per operation.
REQ-028 op_count SHALL saturate at all-ones and not wrap.
REQ-029 A requester that deasserts valid before being granted SHALL lose nothing; no state is kept for unaccepted requests.
REQ-030 rsp_id SHALL identify the accepted requester even when both requesters are valid at accept time.

Reset
REQ-031 While rst is high at an edge, all of the following SHALL be cleared: state = IDLE, prio = 0, rsp_valid = 0, rsp_c = 0, rsp_z = 0, rsp_id = 0, op_count = 0, and the latched operands and sel = 0 (so alu_a = alu_b = alu_sel = 0).
REQ-032 Reset asserted in EXEC or RESP SHALL abort the operation: no response is produced and op_count is unchanged.
REQ-033 While rst is high, req0_ready and req1_ready SHALL be 0.

Verification
In every scenario, the bench ALU stub returns alu_c = alu_a + alu_b mod 2^W and alu_z = (alu_c == 0).
REQ-034 Single request: after reset, req0 presents a=1, b=2, sel=0 with rsp_ready=1 -> req0_ready is high for one cycle; 2 edges later rsp_valid=1, rsp_c=3, rsp_z=0, rsp_id=0; then op_count=1.
REQ-035 Contention: both requesters are valid continuously (req0 a=1 b=2; req1 a=5 b=6) -> grants alternate 0,1,0,1 and responses are 3, 11, 3, 11.
REQ-036 Backpressure: rsp_ready=0 for 10 cycles after rsp_valid rises -> rsp_c stays constant, both readies stay 0, busy=1; once rsp_ready=1, consumption occurs on the next edge.
REQ-037 Zero flag: a=2^18-1, b=1 -> rsp_c=0, rsp_z=1.
REQ-038 Reset mid-operation: rst pulses for one cycle while in EXEC -> rsp_valid stays 0, op_count=0, and the next request completes normally.
REQ-039 Saturation: with CW=2, consume 5 operations -> op_count reads 3 after the 3rd, 4th and 5th.
